// File: rtl/arq_pkg.sv
// Shared ARQ definitions: FSM state encoding, ACK/NAK codes, default parameters
// and a saturating counter helper.
package arq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RESP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FAIL  = 3'd4
  } arq_state_e;

  localparam logic RSP_ACK = 1'b0;
  localparam logic RSP_NAK = 1'b1;

  localparam int ARQ_MAX_RETRY_DEF   = 3;
  localparam int ARQ_TIMEOUT_CYC_DEF = 4096;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/arq_timer.sv
// Retransmission timeout down-counter: load to TIMEOUT_CYC-1, count down while
// enabled, expire_o high while the count sits at zero.
module arq_timer
  import arq_pkg::*;
#(
  parameter int TIMEOUT_CYC = ARQ_TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/arq_ctrl.sv
// ARQ controller: judges each frame's CRC result, issues ACK/NAK (held until accepted),
// retries with timeout, sticky link failure. Define ARQ_CTRL_STATS_EN for frame counters.
module arq_ctrl
  import arq_pkg::*;
#(
  parameter int MAX_RETRY   = ARQ_MAX_RETRY_DEF,
  parameter int TIMEOUT_CYC = ARQ_TIMEOUT_CYC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_arq_en,
  input  logic        i_arq_en_valid,
  input  logic        i_crc_err,
  input  logic        i_crc_err_valid,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_nak,
  output logic [3:0]  o_retry_cnt,
  output logic        o_link_fail,
  input  logic        i_fail_clr
`ifdef ARQ_CTRL_STATS_EN
  ,
  output logic [15:0] o_frm_ok_cnt,
  output logic [15:0] o_frm_err_cnt
`endif
);

  localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

  arq_state_e state_q, state_d;
  logic       arq_en_q, arq_en_d;
  logic [3:0] retry_q, retry_d;
  logic       nak_q, nak_d;

  logic decide, dec_en, dec_err;
  logic tmr_load, tmr_en, tmr_expire;

  arq_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      arq_en_q <= 1'b0;
      retry_q  <= 4'd0;
      nak_q    <= RSP_ACK;
    end else begin
      state_q  <= state_d;
      arq_en_q <= arq_en_d;
      retry_q  <= retry_d;
      nak_q    <= nak_d;
    end
  end

  // A CRC result arriving together with the enable strobe (IDLE or WAIT) is judged
  // against the new enable immediately; a WAIT expiry is judged as a CRC error.
  always_comb begin
    state_d  = state_q;
    arq_en_d = arq_en_q;
    retry_d  = retry_q;
    nak_d    = nak_q;
    decide   = 1'b0;
    dec_en   = arq_en_q;
    dec_err  = i_crc_err;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (i_arq_en_valid) begin
          arq_en_d = i_arq_en;
          state_d  = ST_CHECK;
          if (i_crc_err_valid) begin
            decide = 1'b1;
            dec_en = i_arq_en;
          end
        end else if ((state_q == ST_WAIT) && tmr_expire) begin
          decide  = 1'b1;
          dec_err = 1'b1;
        end
      end
      ST_CHECK: begin
        if (i_crc_err_valid) begin
          decide = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = (nak_q == RSP_NAK) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (i_fail_clr) begin
          state_d = ST_IDLE;
          retry_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (decide) begin
      if (!dec_en) begin
        state_d = ST_IDLE;
      end else if (!dec_err) begin
        state_d = ST_RESP;
        nak_d   = RSP_ACK;
        retry_d = 4'd0;
      end else if (retry_q < MAX_R) begin
        state_d = ST_RESP;
        nak_d   = RSP_NAK;
        retry_d = retry_q + 4'd1;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  always_comb begin
    o_rsp_valid = 1'b0;
    o_rsp_nak   = 1'b0;
    o_link_fail = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_nak   = nak_q;
        tmr_load    = i_rsp_ready && (nak_q == RSP_NAK);
      end
      ST_WAIT: tmr_en      = 1'b1;
      ST_FAIL: o_link_fail = 1'b1;
      default: ;
    endcase
  end

  assign o_retry_cnt = retry_q;

`ifdef ARQ_CTRL_STATS_EN
  logic [STAT_W-1:0] ok_cnt_q, err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (i_crc_err_valid && (state_q != ST_FAIL)) begin
      if (i_crc_err) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end else begin
        ok_cnt_q  <= sat_inc(ok_cnt_q);
      end
    end
  end

  assign o_frm_ok_cnt  = ok_cnt_q;
  assign o_frm_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_arq_ctrl.sv
// Bench for arq_ctrl (MAX_RETRY=2, TIMEOUT_CYC=16): directed scenarios then random
// strobes, every cycle compared against a transaction-level reference model.
module tb_arq_ctrl;

  localparam int MR = 2;
  localparam int TC = 16;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_arq_en, i_arq_en_valid;
  logic        i_crc_err, i_crc_err_valid;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_nak;
  logic [3:0]  o_retry_cnt;
  logic        o_link_fail, i_fail_clr;
`ifdef ARQ_CTRL_STATS_EN
  logic [15:0] o_frm_ok_cnt, o_frm_err_cnt;
`endif

  arq_ctrl #(.MAX_RETRY(MR), .TIMEOUT_CYC(TC)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_arq_en        (i_arq_en),
    .i_arq_en_valid  (i_arq_en_valid),
    .i_crc_err       (i_crc_err),
    .i_crc_err_valid (i_crc_err_valid),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_nak       (o_rsp_nak),
    .o_retry_cnt     (o_retry_cnt),
    .o_link_fail     (o_link_fail),
    .i_fail_clr      (i_fail_clr)
`ifdef ARQ_CTRL_STATS_EN
    ,
    .o_frm_ok_cnt    (o_frm_ok_cnt),
    .o_frm_err_cnt   (o_frm_err_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is open, a response is owed, a retransmission is awaited,
  // or the link is down; countdown is cycles left before the awaited frame is late.
  bit m_open, m_open_en, m_owed, m_owed_nak, m_await, m_down;
  int m_left, m_retry, m_ok, m_err;

  task automatic model_reset();
    m_open = 0; m_open_en = 0; m_owed = 0; m_owed_nak = 0;
    m_await = 0; m_down = 0; m_left = 0; m_retry = 0; m_ok = 0; m_err = 0;
  endtask

  task automatic judge(input bit en, input bit err);
    m_open  = 0;
    m_await = 0;
    if (!en) return;
    if (!err) begin
      m_owed = 1; m_owed_nak = 0; m_retry = 0;
    end else if (m_retry < MR) begin
      m_owed = 1; m_owed_nak = 1; m_retry = m_retry + 1;
    end else begin
      m_down = 1;
    end
  endtask

  task automatic model_step(input bit av, a, cv, c, rdy, clr);
    if (!m_down && cv) begin
      if (c) m_err = (m_err == 65535) ? m_err : m_err + 1;
      else   m_ok  = (m_ok  == 65535) ? m_ok  : m_ok + 1;
    end
    if (m_down) begin
      if (clr) begin m_down = 0; m_retry = 0; end
    end else if (m_owed) begin
      if (rdy) begin
        m_owed = 0;
        if (m_owed_nak) begin m_await = 1; m_left = TC; end
      end
    end else if (m_open) begin
      if (cv) judge(m_open_en, c);
    end else if (av) begin
      m_open = 1; m_open_en = a; m_await = 0;
      if (cv) judge(a, c);
    end else if (m_await) begin
      if (m_left == 1) judge(1'b1, 1'b1);
      else m_left = m_left - 1;
    end
  endtask

  task automatic check_all();
    chk("rsp_valid", o_rsp_valid, m_owed);
    chk("rsp_nak", o_rsp_nak, m_owed & m_owed_nak);
    chk("retry_cnt", o_retry_cnt, m_retry);
    chk("link_fail", o_link_fail, m_down);
`ifdef ARQ_CTRL_STATS_EN
    chk("frm_ok_cnt", o_frm_ok_cnt, m_ok);
    chk("frm_err_cnt", o_frm_err_cnt, m_err);
`endif
  endtask

  task automatic cyc(input bit av, a, cv, c, rdy, clr);
    i_arq_en_valid  = av;
    i_arq_en        = a;
    i_crc_err_valid = cv;
    i_crc_err       = c;
    i_rsp_ready     = rdy;
    i_fail_clr      = clr;
    @(posedge i_clk);
    model_step(av, a, cv, c, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_nak", o_rsp_nak, 0);
    chk("rst_retry", o_retry_cnt, 0);
    chk("rst_link_fail", o_link_fail, 0);
    i_arq_en_valid = 0; i_crc_err_valid = 0; i_rsp_ready = 0; i_fail_clr = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_arq_en = 0; i_arq_en_valid = 0; i_crc_err = 0; i_crc_err_valid = 0;
    i_rsp_ready = 0; i_fail_clr = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // ACK, ready on the first response cycle
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("ack_valid", o_rsp_valid, 1);
    chk("ack_nak", o_rsp_nak, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ack_done", o_rsp_valid, 0);

    // Second enable strobe in CHECK is ignored
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("first_latch", o_rsp_valid, 1);
    cyc(0, 0, 0, 0, 1, 0);

    // Three errored frames: NAK, NAK, link failure
    cyc(1, 1, 1, 1, 1, 0);
    chk("nak1_retry", o_retry_cnt, 1);
    chk("nak1_nak", o_rsp_nak, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("nak2_retry", o_retry_cnt, 2);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("fail_flag", o_link_fail, 1);
    chk("fail_noresp", o_rsp_valid, 0);
    chk("fail_retry_sat", o_retry_cnt, 2);
    cyc(1, 1, 1, 1, 1, 0);
    chk("fail_ignores", o_link_fail, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_link", o_link_fail, 0);
    chk("clr_retry", o_retry_cnt, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Timeout yields the second NAK after 16 cycles
    cyc(1, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TC - 1; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("to_quiet", o_rsp_valid, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("to_valid", o_rsp_valid, 1);
    chk("to_nak", o_rsp_nak, 1);
    chk("to_retry", o_retry_cnt, 2);
    cyc(0, 0, 0, 0, 1, 0);

    // Enable strobe on the expiry cycle beats the timeout
    for (int i = 0; i < TC - 1; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("exp_strobe_nofail", o_link_fail, 0);
    chk("exp_strobe_noresp", o_rsp_valid, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("exp_strobe_ack_retry", o_retry_cnt, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Disabled frame with CRC error: no response, retry unchanged
    cyc(1, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("dis_noresp", o_rsp_valid, 0);
    chk("dis_retry", o_retry_cnt, 1);

    // NAK held with ready low, then reset mid-response
    cyc(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_nak", o_rsp_nak, 1);
    end
    async_reset();

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 6) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
